// File: rtl/spi_ram_arb_pkg.sv
// Shared definitions for the SPI/host RAM arbiter: RAM command opcodes and FSM states.
package spi_ram_arb_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD      = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_CMD,
        RD_WAIT
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers which requester was served last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_one;  // 1 when req[1] was served last, so req[0] wins the next tie

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_one <= 1'b1;
        end else if (advance) begin
            last_one <= grant[1];
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_one ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between two requesters and turns each transaction into
// the RAM's opcode/payload command sequence, returning a one-cycle response.
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_we,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [ADDR_SIZE-1:0] req0_wdata,
    output logic                 rsp0_valid,
    output logic [ADDR_SIZE-1:0] rsp0_rdata,
    output logic                 rsp0_err,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_we,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [ADDR_SIZE-1:0] req1_wdata,
    output logic                 rsp1_valid,
    output logic [ADDR_SIZE-1:0] rsp1_rdata,
    output logic                 rsp1_err,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t                state, state_nx;
    logic [1:0]            grant;
    logic                  handshake;
    logic                  sel_we;
    logic                  owner;
    logic [ADDR_SIZE-1:0]  cap_addr, cap_wdata;
    logic [CW-1:0]         wait_cnt;
    logic                  rsp_done, rsp_err_nx;
    logic [ADDR_SIZE-1:0]  rsp_rdata_nx;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (handshake),
        .grant   (grant)
    );

    assign handshake  = (state == IDLE) && (grant != 2'b00);
    assign sel_we     = grant[1] ? req1_we : req0_we;
    // Gated by rst_n so ready reads 0 while reset is held even if a requester is valid.
    assign req0_ready = rst_n && (state == IDLE) && grant[0];
    assign req1_ready = rst_n && (state == IDLE) && grant[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (handshake) state_nx = sel_we ? WR_ADDR : RD_ADDR;
            WR_ADDR: state_nx = WR_DATA;
            WR_DATA: state_nx = IDLE;
            RD_ADDR: state_nx = RD_CMD;
            RD_CMD:  state_nx = RD_WAIT;
            RD_WAIT: if (ram_tx_valid || (wait_cnt == CNT_LAST)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ram_din      = '0;
        ram_rx_valid = 1'b0;
        case (state)
            WR_ADDR: begin ram_din = {OP_WR_ADDR, cap_addr};  ram_rx_valid = 1'b1; end
            WR_DATA: begin ram_din = {OP_WR_DATA, cap_wdata}; ram_rx_valid = 1'b1; end
            RD_ADDR: begin ram_din = {OP_RD_ADDR, cap_addr};  ram_rx_valid = 1'b1; end
            RD_CMD:  begin ram_din = {OP_RD, {ADDR_SIZE{1'b0}}}; ram_rx_valid = 1'b1; end
            default: begin ram_din = '0; ram_rx_valid = 1'b0; end
        endcase
    end

    // tx_valid is only looked at in RD_WAIT, after RD_ADDR has cleared any stale flag.
    assign rsp_done     = (state == WR_DATA) ||
                          ((state == RD_WAIT) && (ram_tx_valid || (wait_cnt == CNT_LAST)));
    assign rsp_err_nx   = (state == RD_WAIT) && !ram_tx_valid && (wait_cnt == CNT_LAST);
    assign rsp_rdata_nx = ((state == RD_WAIT) && ram_tx_valid) ? ram_dout : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            wait_cnt   <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            if (handshake) begin
                owner     <= grant[1];
                cap_addr  <= grant[1] ? req1_addr  : req0_addr;
                cap_wdata <= grant[1] ? req1_wdata : req0_wdata;
            end
            if (state == RD_CMD) begin
                wait_cnt <= '0;
            end else if (state == RD_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            rsp0_valid <= rsp_done && !owner;
            rsp0_err   <= rsp_err_nx && !owner;
            rsp0_rdata <= (rsp_done && !owner) ? rsp_rdata_nx : '0;
            rsp1_valid <= rsp_done && owner;
            rsp1_err   <= rsp_err_nx && owner;
            rsp1_rdata <= (rsp_done && owner) ? rsp_rdata_nx : '0;
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter with a small behavioural RAM model.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_we;
    logic [7:0] req0_addr, req0_wdata;
    logic       rsp0_valid, rsp0_err;
    logic [7:0] rsp0_rdata;
    logic       req1_valid, req1_ready, req1_we;
    logic [7:0] req1_addr, req1_wdata;
    logic       rsp1_valid, rsp1_err;
    logic [7:0] rsp1_rdata;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    logic [7:0] wa, ra;
    logic       hold_off;

    spi_ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    // RAM: command executes on the edge where rx_valid is high; read data is sticky
    // until the next set-read-address command.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        wa = 8'h00; ra = 8'h00; ram_dout = 8'h00; ram_tx_valid = 1'b0;
    end
    always @(posedge clk) begin
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: wa <= ram_din[7:0];
                2'b01: mem[wa] <= ram_din[7:0];
                2'b10: begin ra <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
                default: if (!hold_off) begin ram_dout <= mem[ra]; ram_tx_valid <= 1'b1; end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input string tag, input logic [9:0] exp_din);
        chk({tag, "_rx"}, 16'(ram_rx_valid), 16'h1);
        chk({tag, "_din"}, 16'(ram_din), 16'(exp_din));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        hold_off = 1'b0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
        #1;
        chk("rst_din", 16'(ram_din), 16'h0);
        chk("rst_rx", 16'(ram_rx_valid), 16'h0);
        chk("rst_rsp", 16'({rsp0_valid, rsp0_err, rsp1_valid, rsp1_err}), 16'h0);
        chk("rst_rdata", {rsp0_rdata, rsp1_rdata}, 16'h0);
        step_n(2);
        rst_n = 1'b1;
        step();

        // Contention A: req0 wins the first tie, req1 is granted in rsp0's cycle
        req0_valid = 1; req0_we = 1; req0_addr = 8'h20; req0_wdata = 8'h11;
        req1_valid = 1; req1_we = 1; req1_addr = 8'h21; req1_wdata = 8'h22;
        #1;
        chk("ca_rdy", 16'({req1_ready, req0_ready}), 16'h1);
        step(); req0_valid = 0; #1;
        chk("ca_rdy_busy", 16'({req1_ready, req0_ready}), 16'h0);
        cmd("ca_wa0", 10'h020);
        step(); cmd("ca_wd0", 10'h111);
        step();
        chk("ca_rsp0", 16'({rsp1_valid, rsp0_valid, rsp0_err}), 16'h2);
        chk("ca_rdy1", 16'({req1_ready, req0_ready}), 16'h2);
        step(); req1_valid = 0;
        cmd("ca_wa1", 10'h021);
        step(); cmd("ca_wd1", 10'h122);
        step();
        chk("ca_rsp1", 16'({rsp1_valid, rsp1_err, rsp0_valid}), 16'h4);

        // Single write req0 0x12 = 0xA5
        req0_valid = 1; req0_we = 1; req0_addr = 8'h12; req0_wdata = 8'hA5;
        #1; chk("w_rdy", 16'(req0_ready), 16'h1);
        step(); req0_valid = 0;
        cmd("w_wa", 10'h012);
        chk("w_nrsp", 16'(rsp0_valid), 16'h0);
        step(); cmd("w_wd", 10'h1A5);
        step();
        chk("w_rsp", 16'({rsp0_valid, rsp0_err}), 16'h2);
        chk("w_rdata", 16'(rsp0_rdata), 16'h0);
        chk("w_idle_rx", 16'(ram_rx_valid), 16'h0);

        // Read req0 0x12
        req0_valid = 1; req0_we = 0; req0_addr = 8'h12;
        step(); req0_valid = 0;
        cmd("r_ra", 10'h212);
        step(); cmd("r_rd", 10'h300);
        step(); chk("r_wait_rx", 16'(ram_rx_valid), 16'h0);
        chk("r_nrsp", 16'(rsp0_valid), 16'h0);
        step();
        chk("r_rsp", 16'({rsp0_valid, rsp0_err}), 16'h2);
        chk("r_rdata", 16'(rsp0_rdata), 16'h00A5);

        // Contention B: req0 was served last, so req1 wins
        req0_valid = 1; req0_we = 1; req0_addr = 8'h30; req0_wdata = 8'h33;
        req1_valid = 1; req1_we = 1; req1_addr = 8'h31; req1_wdata = 8'h44;
        #1;
        chk("cb_rdy", 16'({req1_ready, req0_ready}), 16'h2);
        step(); req1_valid = 0;
        cmd("cb_wa1", 10'h031);
        step(); cmd("cb_wd1", 10'h144);
        step();
        chk("cb_rsp1", 16'({rsp1_valid, rsp0_valid}), 16'h2);
        chk("cb_rdy0", 16'({req1_ready, req0_ready}), 16'h1);
        step(); req0_valid = 0;
        cmd("cb_wa0", 10'h030);
        step_n(2);
        chk("cb_rsp0", 16'({rsp1_valid, rsp0_valid}), 16'h1);

        // Timeout: RAM never raises tx_valid
        hold_off = 1;
        req1_valid = 1; req1_we = 0; req1_addr = 8'h40;
        #1; chk("to_rdy", 16'(req1_ready), 16'h1);
        step(); req1_valid = 0;
        cmd("to_ra", 10'h240);
        step(); cmd("to_rd", 10'h300);
        step_n(4);
        chk("to_early", 16'({rsp1_valid, rsp0_valid}), 16'h0);
        chk("to_wait_rx", 16'(ram_rx_valid), 16'h0);
        step();
        chk("to_rsp", 16'({rsp1_valid, rsp1_err, rsp0_valid}), 16'h6);
        chk("to_rdata", 16'(rsp1_rdata), 16'h0);
        chk("to_idle", 16'({ram_rx_valid, ram_din}), 16'h0);
        hold_off = 0;
        step();

        // Reset during RD_CMD
        req0_valid = 1; req0_we = 0; req0_addr = 8'h12;
        step(); req0_valid = 0;
        step(); cmd("rr_rd", 10'h300);
        req1_valid = 1; req1_we = 0; req1_addr = 8'h12;
        rst_n = 0;
        #1;
        chk("rr_din", 16'({ram_rx_valid, ram_din}), 16'h0);
        chk("rr_rdy", 16'({req1_ready, req0_ready}), 16'h0);
        chk("rr_rsp", 16'({rsp0_valid, rsp0_err, rsp1_valid, rsp1_err}), 16'h0);
        step();
        chk("rr_hold", 16'({rsp0_valid, rsp1_valid, ram_rx_valid}), 16'h0);
        req1_valid = 0;
        rst_n = 1;
        step_n(2);
        chk("rr_nopulse", 16'({rsp0_valid, rsp1_valid}), 16'h0);
        req0_valid = 1; req0_we = 0; req0_addr = 8'h12;
        step(); req0_valid = 0;
        cmd("rr2_ra", 10'h212);
        step_n(3);
        chk("rr2_rsp", 16'({rsp0_valid, rsp0_err}), 16'h2);
        chk("rr2_rdata", 16'(rsp0_rdata), 16'h00A5);

        // Stale tx_valid: write 0x13, then back-to-back reads of 0x12 and 0x13
        req0_valid = 1; req0_we = 1; req0_addr = 8'h13; req0_wdata = 8'h5C;
        step(); req0_valid = 0;
        step_n(2);
        chk("st_wrsp", 16'(rsp0_valid), 16'h1);
        req0_valid = 1; req0_we = 0; req0_addr = 8'h12;
        #1; chk("st_rdy_b2b", 16'(req0_ready), 16'h1);
        step(); req0_addr = 8'h13;
        step_n(3);
        chk("st_rsp_a", 16'(rsp0_valid), 16'h1);
        chk("st_rdata_a", 16'(rsp0_rdata), 16'h00A5);
        chk("st_rdy_b", 16'(req0_ready), 16'h1);
        step(); req0_valid = 0;
        cmd("st_ra_b", 10'h213);
        step_n(3);
        chk("st_rsp_b", 16'({rsp0_valid, rsp0_err}), 16'h2);
        chk("st_rdata_b", 16'(rsp0_rdata), 16'h005C);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares one single-port RAM between two requesters: req0 (SPI slave side) and req1 (host/debug side).
- Turns each requester transaction into the RAM's 10-bit command sequence:
  - opcode 00: set write address
  - opcode 01: write data
  - opcode 10: set read address
  - opcode 11: read
- Collects the RAM read data and returns a one-cycle response to the requester that issued the transaction.
- Sits between the requester ports and the RAM's din/rx_valid/dout/tx_valid pins.

Parameters:
- ADDR_SIZE, 8, RAM address and data width.
- TIMEOUT, 4, maximum RD_WAIT cycles allowed for tx_valid before an error response; minimum value is 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- reqN_valid  in  1  requester N (N = 0, 1) has a transaction pending.
- reqN_ready  out  1  requester N transaction accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_SIZE  target address.
- reqN_wdata  in  ADDR_SIZE  write data; ignored for reads.
- rspN_valid  out  1  one-cycle completion pulse for requester N.
- rspN_rdata  out  ADDR_SIZE  read data; 0 for writes and errors.
- rspN_err  out  1  read timed out; qualified by rspN_valid.
- ram_din  out  ADDR_SIZE+2  RAM command word {opcode[1:0], payload}.
- ram_rx_valid  out  1  RAM command strobe.
- ram_dout  in  ADDR_SIZE  RAM read data.
- ram_tx_valid  in  1  RAM read data valid.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE.
  - All outputs are 0: ram_din, ram_rx_valid, reqN_ready, rspN_valid, rspN_rdata, rspN_err.
  - Round-robin pointer set so req0 wins the first contention.
  - Reset mid-transaction abandons the transaction with no response. The RAM may hold a partially updated address register; this is acceptable.
- Handshake: valid/ready.
  - A requester holds valid and its fields stable until it sees ready.
  - reqN_ready is combinational: high only in IDLE for the granted requester.
  - Fields are captured on the edge where valid and ready are both high.
- Arbitration: round-robin in IDLE.
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester not served last.
  - The pointer updates only on an accepted handshake.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT.
  - IDLE: on handshake, go to WR_ADDR if we=1, else RD_ADDR.
  - WR_ADDR: ram_din={00,addr}, ram_rx_valid=1; go to WR_DATA.
  - WR_DATA: ram_din={01,wdata}, ram_rx_valid=1; go to IDLE and schedule the response.
  - RD_ADDR: ram_din={10,addr}, ram_rx_valid=1; go to RD_CMD. The RAM clears tx_valid on this command.
  - RD_CMD: ram_din={11,0}, ram_rx_valid=1; go to RD_WAIT and clear the wait counter.
  - RD_WAIT: ram_din={00,0}, ram_rx_valid=0.
    - ram_tx_valid=1: capture ram_dout, respond with err=0, go to IDLE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT: respond with err=1, rdata=0, go to IDLE.
  - IDLE with no grant: ram_din={00,0}, ram_rx_valid=0, so the RAM does nothing.
- ram_din and ram_rx_valid are decoded from the state and captured-request registers only, never from requester inputs.
- Responses:
  - rspN_* are registered and high for exactly one cycle, in the cycle the FSM is back in IDLE.
  - A new grant may be given in that same cycle.
  - Only the owning requester's rsp is pulsed; the other requester's rsp outputs stay 0.
- Latency from the handshake edge to rsp_valid high:
  - write: 3 cycles.
  - read: 4 cycles with a RAM that responds immediately.
  - read timeout: 3+TIMEOUT cycles.
- Back-to-back throughput is one transaction per 3 (write) or 4 (read) cycles.
- A stale tx_valid=1 left over from an earlier read is never sampled: RD_ADDR always precedes RD_WAIT.

Decomposition:
- Package spi_ram_arb_pkg holds:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD=2'b11.
  - the state enum typedef.
- Sub-module rr_arbiter2: inputs req[1:0] and advance; outputs a one-hot grant[1:0]; holds the last-served pointer.

Test Plan:
- Single write: req0 write addr=0x12 wdata=0xA5.
  - Required: ram_din sequence 0x012, then 0x1A5 with rx_valid, then rsp0_valid 3 cycles after the handshake with err=0.
- Write then read: req0 write 0x12=0xA5, then req0 read 0x12.
  - Required: ram_din 0x212, then 0x300; rsp0_rdata=0xA5 4 cycles after the handshake.
- Contention: req0 and req1 both valid with writes in the same cycle.
  - Required: req0 granted first, req1 granted in the cycle of rsp0_valid.
  - Repeat the contention: req1 wins this time.
- Timeout: RAM model holds tx_valid=0, req1 read addr=0x40.
  - Required: rsp1_valid with err=1, rdata=0 after 3+TIMEOUT=7 cycles; FSM back in IDLE.
- Reset mid-read: assert rst_n=0 during RD_CMD.
  - Required: all outputs 0 immediately (asynchronous) and no rsp pulse.
  - After release, req0 read addr=0x12 returns the prior contents 0xA5.
- Stale tx_valid: two back-to-back reads, to 0x12 and then 0x13 (0x13 written as 0x5C).
  - Required: the second response returns 0x5C, not 0xA5.
